// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider with per-channel pending config
// that is applied only at a period boundary, plus a global phase-align sync.
module clk_div_prog #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  input  logic [DIV_W-1:0]  cfg_high_i,
  input  logic              sync_i,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] tick_o
);

  localparam int              PEXT     = 1 << CH_W;
  localparam logic [DIV_W-1:0] ZERO     = '0;
  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DEF_HIGH = DIV_W'(DEFAULT_DIV / 2);
  localparam logic [DIV_W-1:0] DEF_CNT  = DIV_W'(DEFAULT_DIV - 1);

  logic [DIV_W-1:0]  r_div   [NUM_CH];
  logic [DIV_W-1:0]  r_high  [NUM_CH];
  logic [DIV_W-1:0]  r_pdiv  [NUM_CH];
  logic [DIV_W-1:0]  r_phigh [NUM_CH];
  logic [DIV_W-1:0]  r_cnt   [NUM_CH];
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_clk;
  logic [NUM_CH-1:0] r_tick;

  logic [DIV_W-1:0]  w_div_nx   [NUM_CH];
  logic [DIV_W-1:0]  w_high_nx  [NUM_CH];
  logic [DIV_W-1:0]  w_pdiv_nx  [NUM_CH];
  logic [DIV_W-1:0]  w_phigh_nx [NUM_CH];
  logic [DIV_W-1:0]  w_cnt_nx   [NUM_CH];
  logic [NUM_CH-1:0] w_pend_nx;
  logic [NUM_CH-1:0] w_clk_nx;
  logic [NUM_CH-1:0] w_tick_nx;
  logic [NUM_CH-1:0] w_acc;
  logic [NUM_CH-1:0] w_wrap;
  logic [NUM_CH-1:0] w_apply;
  logic [PEXT-1:0]   w_pend_ext;

  // Zero-padded pending vector so out-of-range channel indices read as ready
  always_comb begin
    w_pend_ext = '0;
    w_pend_ext[NUM_CH-1:0] = r_pend;
  end

  assign cfg_ready_o = ~w_pend_ext[cfg_ch_i];

  // Next-state per channel: apply pending at wrap, on sync, or immediately when disabled
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_acc[c]   = cfg_valid_i & cfg_ready_o & (cfg_ch_i == CH_W'(c));
      w_wrap[c]  = (r_div[c] != ZERO) && (r_cnt[c] == r_div[c] - ONE);
      w_apply[c] = sync_i | w_wrap[c] | ((r_div[c] == ZERO) & r_pend[c]);

      if (w_apply[c] && r_pend[c]) begin
        w_div_nx[c]  = r_pdiv[c];
        w_high_nx[c] = r_phigh[c];
      end else begin
        w_div_nx[c]  = r_div[c];
        w_high_nx[c] = r_high[c];
      end

      if (w_apply[c]) begin
        w_cnt_nx[c] = ZERO;
      end else if (r_div[c] == ZERO) begin
        w_cnt_nx[c] = ZERO;
      end else begin
        w_cnt_nx[c] = r_cnt[c] + ONE;
      end

      // A transfer only happens while nothing is pending, so a new request survives the apply
      w_pend_nx[c] = w_apply[c] ? w_acc[c] : (r_pend[c] | w_acc[c]);

      if (w_acc[c]) begin
        w_pdiv_nx[c]  = cfg_div_i;
        w_phigh_nx[c] = cfg_high_i;
      end else begin
        w_pdiv_nx[c]  = r_pdiv[c];
        w_phigh_nx[c] = r_phigh[c];
      end

      w_clk_nx[c]  = (w_div_nx[c] != ZERO) && (w_cnt_nx[c] < w_high_nx[c]);
      w_tick_nx[c] = (w_div_nx[c] != ZERO) && (w_cnt_nx[c] == ZERO);
    end
  end

  // State registers with synchronous reset to the default divisor
  always_ff @(posedge clk_i) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_div[c]   <= DEF_DIV;
        r_high[c]  <= DEF_HIGH;
        r_pdiv[c]  <= ZERO;
        r_phigh[c] <= ZERO;
        r_cnt[c]   <= DEF_CNT;
      end
      r_pend <= '0;
      r_clk  <= '0;
      r_tick <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_div[c]   <= w_div_nx[c];
        r_high[c]  <= w_high_nx[c];
        r_pdiv[c]  <= w_pdiv_nx[c];
        r_phigh[c] <= w_phigh_nx[c];
        r_cnt[c]   <= w_cnt_nx[c];
      end
      r_pend <= w_pend_nx;
      r_clk  <= w_clk_nx;
      r_tick <= w_tick_nx;
    end
  end

  assign clk_o  = r_clk;
  assign tick_o = r_tick;

endmodule
